// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header
//
// Removes a per-packet number of leading bytes from an AXI-Stream packet and
// emits them on a one-beat header channel. The remaining payload is
// re-aligned so that it starts at byte 0 of the first output beat.
//
// Ports:
//   clk, rst_n          single rising-edge clock, asynchronous active-low reset
//   valid_in/data_in/keep_in/last_in/ready_in
//                       input packet stream (byte 0 = data_in[DATA_WD-1 -: 8],
//                       keep MSB-aligned and contiguous)
//   valid_out/data_out/keep_out/last_out/ready_out
//                       re-aligned payload stream, registered
//   valid_strip/byte_strip_cnt/ready_strip
//                       per-packet strip command, accepted only while idle
//   valid_header/data_header/keep_header/ready_header
//                       stripped bytes, right-aligned, single-entry register
//   dbg_state_o         FSM state (0 IDLE, 1 FIRST, 2 BODY, 3 FLUSH)
//
// Handshake: on every channel a transfer happens on a rising edge where valid
// and ready are both high. A valid, once raised, holds its data stable until
// the transfer. Output valids are pure register outputs and never depend on
// ready_out or ready_header in the same cycle.
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
  output logic                    ready_strip,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  input  logic                    ready_header,
  output logic [1:0]              dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    BODY  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [BYTE_CNT_WD-1:0]  cnt_q, cnt_d;
  logic [DATA_WD-1:0]      res_q, res_d;       // residue, MSB-aligned
  logic [BYTE_CNT_WD:0]    res_n_q, res_n_d;   // residue bytes left for FLUSH
  logic                    vout_q, vout_d;
  logic [DATA_WD-1:0]      dout_q, dout_d;
  logic [DATA_BYTE_WD-1:0] kout_q, kout_d;
  logic                    lout_q, lout_d;
  logic                    vhdr_q, vhdr_d;
  logic [DATA_WD-1:0]      dhdr_q, dhdr_d;
  logic [DATA_BYTE_WD-1:0] khdr_q, khdr_d;

  logic                    ready_in_c, ready_strip_c, out_free, load_c, ld_last;
  logic [DATA_WD-1:0]      dm, body_w, ld_data;
  logic [DATA_BYTE_WD-1:0] ld_keep;
  int                      k, c, r, hk, cnt_in;

  function automatic int popcnt(input logic [DATA_BYTE_WD-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < DATA_BYTE_WD; i++) if (v[i]) n++;
    return n;
  endfunction

  // MSB-aligned enables for n bytes (n = DATA_BYTE_WD gives all ones).
  function automatic logic [DATA_BYTE_WD-1:0] keep_top(input int n);
    return ~({DATA_BYTE_WD{1'b1}} >> n);
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] kp);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[i*8 +: 8] = {8{kp[i]}};
    return m;
  endfunction

  // Byte shifts are done on a double-width word so a shift by the full
  // beat width yields zero instead of an out-of-range shift.
  function automatic logic [DATA_WD-1:0] shl_bytes(input logic [DATA_WD-1:0] d, input int n);
    logic [2*DATA_WD-1:0] w;
    w = {{DATA_WD{1'b0}}, d} << (n * 8);
    return w[DATA_WD-1:0];
  endfunction

  function automatic logic [DATA_WD-1:0] shr_bytes(input logic [DATA_WD-1:0] d, input int n);
    logic [2*DATA_WD-1:0] w;
    w = {{DATA_WD{1'b0}}, d} >> (n * 8);
    return w[DATA_WD-1:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    res_n_d  = res_n_q;
    vout_d   = vout_q;
    dout_d   = dout_q;
    kout_d   = kout_q;
    lout_d   = lout_q;
    vhdr_d   = vhdr_q;
    dhdr_d   = dhdr_q;
    khdr_d   = khdr_q;
    ready_in_c    = 1'b0;
    ready_strip_c = 1'b0;
    load_c   = 1'b0;
    ld_data  = '0;
    ld_keep  = '0;
    ld_last  = 1'b0;
    out_free = ~vout_q | ready_out;
    dm       = data_in & byte_mask(keep_in);
    k        = popcnt(keep_in);
    c        = int'(cnt_q);
    r        = DATA_BYTE_WD - c;
    hk       = (c < k) ? c : k;
    cnt_in   = int'(byte_strip_cnt);
    body_w   = res_q | shr_bytes(dm, r);

    if (vout_q && ready_out)    vout_d = 1'b0;
    if (vhdr_q && ready_header) vhdr_d = 1'b0;

    case (state_q)
      IDLE: begin
        ready_strip_c = 1'b1;
        if (valid_strip) begin
          if (cnt_in > DATA_BYTE_WD - 1) cnt_in = DATA_BYTE_WD - 1;
          cnt_d   = BYTE_CNT_WD'(cnt_in);
          state_d = FIRST;
        end
      end
      FIRST: begin
        ready_in_c = ~vhdr_q & out_free;
        if (valid_in && ready_in_c) begin
          vhdr_d = 1'b1;
          dhdr_d = shr_bytes(dm, DATA_BYTE_WD - hk);
          khdr_d = ~({DATA_BYTE_WD{1'b1}} << hk);
          res_d  = shl_bytes(dm, c);
          if (c == 0) begin
            load_c  = 1'b1;
            ld_data = dm;
            ld_keep = keep_in;
            ld_last = last_in;
            state_d = last_in ? IDLE : BODY;
          end else if (last_in) begin
            // Short packet: whatever survives the strip fits in one beat.
            if (k > c) begin
              load_c  = 1'b1;
              ld_data = shl_bytes(dm, c);
              ld_keep = keep_top(k - c);
              ld_last = 1'b1;
            end
            state_d = IDLE;
          end else begin
            state_d = BODY;
          end
        end
      end
      BODY: begin
        ready_in_c = out_free;
        if (valid_in && ready_in_c) begin
          if (c == 0) begin
            // Nothing stripped: no residue, beats pass straight through.
            load_c  = 1'b1;
            ld_data = dm;
            ld_keep = keep_in;
            ld_last = last_in;
            if (last_in) state_d = IDLE;
          end else begin
            load_c  = 1'b1;
            ld_data = body_w;
            res_d   = shl_bytes(dm, c);
            if (last_in && k <= c) begin
              ld_keep = keep_top(r + k);
              ld_last = 1'b1;
              state_d = IDLE;
            end else begin
              ld_keep = '1;
              if (last_in) begin
                res_n_d = (BYTE_CNT_WD+1)'(k - c);
                state_d = FLUSH;
              end
            end
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          load_c  = 1'b1;
          ld_data = res_q;
          ld_keep = keep_top(int'(res_n_q));
          ld_last = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A reload on the same edge as a drain wins over the drain above.
    if (load_c) begin
      vout_d = 1'b1;
      dout_d = ld_data;
      kout_d = ld_keep;
      lout_d = ld_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      res_n_q <= '0;
      vout_q  <= 1'b0;
      dout_q  <= '0;
      kout_q  <= '0;
      lout_q  <= 1'b0;
      vhdr_q  <= 1'b0;
      dhdr_q  <= '0;
      khdr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      res_n_q <= res_n_d;
      vout_q  <= vout_d;
      dout_q  <= dout_d;
      kout_q  <= kout_d;
      lout_q  <= lout_d;
      vhdr_q  <= vhdr_d;
      dhdr_q  <= dhdr_d;
      khdr_q  <= khdr_d;
    end
  end

  // ready_strip is gated by rst_n so it reads 0 while reset is held even
  // though the state register already sits in IDLE.
  assign ready_strip  = ready_strip_c & rst_n;
  assign ready_in     = ready_in_c;
  assign valid_out    = vout_q;
  assign data_out     = dout_q;
  assign keep_out     = kout_q;
  assign last_out     = lout_q;
  assign valid_header = vhdr_q;
  assign data_header  = dhdr_q;
  assign keep_header  = khdr_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
module tb_axi_stream_strip_header;
  localparam int DATA_WD = 32;
  localparam int DBW     = DATA_WD / 8;
  localparam int CW      = $clog2(DBW);

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             valid_in = 1'b0;
  logic [DATA_WD-1:0] data_in = '0;
  logic [DBW-1:0]   keep_in = '0;
  logic             last_in = 1'b0;
  logic             ready_in;
  logic             valid_out;
  logic [DATA_WD-1:0] data_out;
  logic [DBW-1:0]   keep_out;
  logic             last_out;
  logic             ready_out = 1'b0;
  logic             valid_strip = 1'b0;
  logic [CW-1:0]    byte_strip_cnt = '0;
  logic             ready_strip;
  logic             valid_header;
  logic [DATA_WD-1:0] data_header;
  logic [DBW-1:0]   keep_header;
  logic             ready_header = 1'b0;
  logic [1:0]       dbg_state;

  axi_stream_strip_header #(.DATA_WD(DATA_WD)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .valid_strip(valid_strip), .byte_strip_cnt(byte_strip_cnt), .ready_strip(ready_strip),
    .valid_header(valid_header), .data_header(data_header), .keep_header(keep_header),
    .ready_header(ready_header),
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_WD+DBW:0]   exp_q[$];    // {data, keep, last}
  logic [DATA_WD+DBW-1:0] exp_h_q[$];  // {data, keep}
  logic [7:0]             pkt_b[$];
  bit mon_en   = 1'b1;
  bit rand_out = 1'b0;
  bit rand_hdr = 1'b0;
  bit hdr_hold = 1'b0;
  int stalls;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sink ready drivers
  initial forever begin
    @(posedge clk); #1;
    ready_out    = rand_out ? 1'($urandom_range(0, 1)) : 1'b1;
    ready_header = hdr_hold ? 1'b0 : (rand_hdr ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // scoreboard: compare at the falling edge every transfer that the next
  // rising edge will complete
  logic [DATA_WD+DBW:0] prev_out;
  bit prev_stall = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst_n || !mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {valid_out, data_out, keep_out, last_out}, {1'b1, prev_out});
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) chk("payload_unexpected", 1, 0);
        else chk("payload", {data_out, keep_out, last_out}, exp_q.pop_front());
      end
      if (valid_header && ready_header) begin
        if (exp_h_q.size() == 0) chk("header_unexpected", 1, 0);
        else chk("header", {data_header, keep_header}, exp_h_q.pop_front());
      end
      prev_stall = valid_out && !ready_out;
      prev_out   = {data_out, keep_out, last_out};
    end
  end

  // reference model: header = first min(cnt,len) bytes right-aligned;
  // payload = remaining bytes chunked into beats, last flag on the final one
  task automatic model_packet(input int cnt);
    int len;
    int hk;
    logic [DATA_WD-1:0] h;
    len = pkt_b.size();
    hk  = (cnt < len) ? cnt : len;
    h   = '0;
    for (int i = 0; i < hk; i++) h = (h << 8) | DATA_WD'(pkt_b[i]);
    exp_h_q.push_back({h, DBW'((1 << hk) - 1)});
    for (int p = cnt; p < len; p += DBW) begin
      logic [DATA_WD-1:0] d;
      logic [DBW-1:0] kp;
      int n;
      d = '0; kp = '0;
      n = (len - p < DBW) ? len - p : DBW;
      for (int j = 0; j < n; j++) begin
        d[DATA_WD-1-8*j -: 8] = pkt_b[p+j];
        kp[DBW-1-j] = 1'b1;
      end
      exp_q.push_back({d, kp, 1'(p + DBW >= len)});
    end
  endtask

  // driver tasks (entered and left at posedge + 1)
  task automatic push_bytes(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) pkt_b.push_back(w[31-8*i -: 8]);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) pkt_b.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_strip(input int cnt);
    int t;
    t = 0;
    valid_strip = 1'b1;
    byte_strip_cnt = CW'(cnt);
    forever begin
      @(negedge clk);
      if (ready_strip) break;
      t++;
      if (t > 2000) begin chk("strip_timeout", 1, 0); break; end
    end
    @(posedge clk); #1;
    valid_strip = 1'b0;
  endtask

  task automatic drive_beat(input int p);
    int n;
    n = (pkt_b.size() - p < DBW) ? pkt_b.size() - p : DBW;
    data_in = '0; keep_in = '0;
    for (int j = 0; j < n; j++) begin
      data_in[DATA_WD-1-8*j -: 8] = pkt_b[p+j];
      keep_in[DBW-1-j] = 1'b1;
    end
    last_in  = (p + DBW >= pkt_b.size());
    valid_in = 1'b1;
  endtask

  task automatic wait_accept(output int st);
    st = 0;
    forever begin
      @(negedge clk);
      if (ready_in) break;
      st++;
      if (st > 2000) begin chk("accept_timeout", 1, 0); break; end
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic send_packet(input int cnt);
    int st;
    model_packet(cnt);
    send_strip(cnt);
    stalls = 0;
    for (int p = 0; p < pkt_b.size(); p += DBW) begin
      drive_beat(p);
      wait_accept(st);
      if (p > 0) stalls += st;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp_h_q.size() != 0) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_payload_left", exp_q.size(), 0);
    chk("drain_header_left", exp_h_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid_out"}, valid_out, 0);
    chk({tag, "_payload"}, {data_out, keep_out, last_out}, 0);
    chk({tag, "_header"}, {valid_header, keep_header, data_header}, 0);
    chk({tag, "_readies"}, {ready_in, ready_strip}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready_strip", ready_strip, 1);
    @(posedge clk); #1;

    // cnt=1, three full beats, flush beat at the end, no input bubbles
    pkt_b.delete();
    push_bytes(32'hAABBCCDD, 4); push_bytes(32'hEEFF0011, 4); push_bytes(32'h22334455, 4);
    send_packet(1);
    chk("t1_no_bubbles", stalls, 0);
    drain();

    // cnt=2, single last beat
    pkt_b.delete();
    push_bytes(32'h11223344, 4);
    send_packet(2);
    drain();

    // cnt=3, short last beat folds into one output beat, no flush
    pkt_b.delete();
    push_bytes(32'h01020304, 4); push_bytes(32'h05060000, 2);
    send_packet(3);
    drain();

    // cnt=0 pass-through with random output back-pressure
    rand_out = 1'b1;
    pkt_b.delete();
    push_random(8);
    send_packet(0);
    drain();
    rand_out = 1'b0;

    // header held: next packet's first beat must wait for the header handshake
    hdr_hold = 1'b1;
    @(posedge clk); #1;
    pkt_b.delete();
    push_random(8);
    send_packet(1);
    pkt_b.delete();
    push_random(7);
    model_packet(2);
    send_strip(2);
    drive_beat(0);
    repeat (5) begin
      @(negedge clk);
      chk("hdr_block_ready_in", ready_in, 0);
    end
    @(posedge clk); #1;
    hdr_hold = 1'b0;
    wait_accept(st);
    drive_beat(4);
    wait_accept(st);
    drain();

    // randomized packets with random back-pressure on both sinks
    rand_out = 1'b1;
    rand_hdr = 1'b1;
    for (int i = 0; i < 25; i++) begin
      pkt_b.delete();
      push_random($urandom_range(1, 13));
      send_packet($urandom_range(0, DBW - 1));
    end
    drain();

    // reset in the middle of a packet
    mon_en = 1'b0;
    rand_out = 1'b0;
    rand_hdr = 1'b0;
    pkt_b.delete();
    push_random(16);
    send_strip(2);
    drive_beat(0); wait_accept(st);
    drive_beat(4); wait_accept(st);
    chk("mid_body_state", dbg_state, 2);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    chk("midrst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("midrst_ready_strip", ready_strip, 1);
    chk("midrst_no_stale_out", {valid_out, valid_header}, 0);
    @(posedge clk); #1;
    pkt_b.delete();
    push_bytes(32'hC0C1C2C3, 4); push_bytes(32'hC4C5C6C7, 4); push_bytes(32'hC8000000, 1);
    send_packet(3);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_stream_strip_header.md
Name: axi_stream_strip_header

Overview:
- Downstream counterpart of the header-insert stage: removes a per-packet count of leading bytes from an AXI-Stream packet and re-aligns the remaining payload to beat boundaries.
- Stripped bytes go out on a separate one-beat header channel.
- Used at the receive side to recover header and payload, and in loopback benches to undo header insertion.

Parameters:
- DATA_WD, 32, stream data width in bits (multiple of 8).
- DATA_BYTE_WD, DATA_WD/8, bytes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of the strip count.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  input beat valid.
- data_in  input  DATA_WD  input data; byte 0 of the stream is data_in[DATA_WD-1 -: 8].
- keep_in  input  DATA_BYTE_WD  MSB-aligned contiguous byte enables; all ones except possibly on the last beat.
- last_in  input  1  last beat of packet.
- ready_in  output  1  input accept.
- valid_out, data_out, keep_out, last_out  output  1/DATA_WD/DATA_BYTE_WD/1  payload stream, same byte conventions as the input.
- ready_out  input  1  payload accept.
- valid_strip  input  1  strip command valid.
- byte_strip_cnt  input  BYTE_CNT_WD  number of leading bytes to remove, 0..DATA_BYTE_WD-1.
- ready_strip  output  1  strip command accept.
- valid_header  output  1  header valid.
- data_header  output  DATA_WD  stripped bytes, right-aligned; unused upper bytes are 0.
- keep_header  output  DATA_BYTE_WD  right-aligned enables for data_header.
- ready_header  input  1  header accept.

Behaviour:
- Reset: all outputs driven 0 (valid_out, last_out, keep_out, data_out, valid_header, keep_header, data_header, ready_in, ready_strip). The state machine returns to IDLE immediately on rst_n low. Any in-flight packet is discarded and no partial output appears after reset release.
- Handshake: a transfer occurs when valid and ready are both high. Output valids never depend combinationally on ready_out or ready_header.
- FSM:
  - IDLE: ready_strip=1, ready_in=0. A strip handshake latches cnt and moves to FIRST.
  - FIRST: ready_in = ~valid_header_reg & (~valid_out | ready_out). On accept:
    - The top cnt bytes go to the header register, right-aligned, with keep_header = (1<<k)-1, where k = min(cnt, valid bytes of the beat). valid_header is set even when cnt=0, with keep_header=0.
    - The remaining bytes are held as a residue of R = DATA_BYTE_WD-cnt bytes.
    - If cnt=0, the beat passes straight to the output register; a non-last beat goes to BODY, a last beat goes to IDLE.
    - If last_in and the beat's valid bytes <= cnt: no payload is emitted and the FSM goes to IDLE.
    - If last_in with more bytes than cnt: emit one payload beat of (valid-cnt) bytes, last_out=1, then go to IDLE.
    - Otherwise go to BODY.
  - BODY: same ready_in rule, minus the header term. For a beat with k valid bytes, output = {residue, top cnt bytes of the beat}, and the residue becomes the beat's lower R bytes.
    - If last_in and k<=cnt: output has R+k bytes, last_out=1, go to IDLE.
    - If last_in and k>cnt: output is a full beat with last_out=0, then go to FLUSH.
  - FLUSH: ready_in=0. Emit the residue of k-cnt bytes with last_out=1 once the output register is free, then go to IDLE.
- Latency: payload out is registered; a beat appears on the cycle after the accepting edge. The output register holds while valid_out & ~ready_out. Full throughput of one beat per cycle with no stalls.
- Header register: a single entry, held until ready_header. It blocks only the next packet's FIRST beat, not BODY beats.
- Width rules:
  - keep_out is always ((1<<n)-1) << (DATA_BYTE_WD-n) for n bytes.
  - data bytes outside keep_out are 0.
  - All shifts are by byte count×8, computed at 2*DATA_WD width, with no truncation.
- Simultaneous events: a strip command for the next packet is accepted only in IDLE. The output register may drain and reload on the same edge.
- Protocol violation: byte_strip_cnt >= DATA_BYTE_WD cannot occur for the default width. For non-power-of-2 widths the count is clamped to DATA_BYTE_WD-1.

Test Plan:
- Strip cnt=1, 3-beat packet AABBCCDD, EEFF0011, 22334455 with keep F,F,F. Required: header 0x000000AA keep 1; payload BBCCDDEE keep F, FF001122 keep F, 33445500 keep E with last. No bubbles when ready_out=1.
- cnt=2, single beat 11223344 keep F, last. Required: header 0x00001122 keep 3; one payload beat 33440000 keep C with last.
- cnt=3, 2 beats 01020304 (keep F) then 05060000 keep C, last. Required: header 0x00010203 keep 7; payload 04050600 keep E with last, and no FLUSH beat.
- cnt=0 pass-through of 2 beats with random ready_out (~50% duty). Required: output is identical to input; header valid with keep 0; data stays stable while stalled.
- Back-to-back packets with ready_header held low for 5 cycles. Required: the second packet's first beat is not accepted (ready_in=0) until the header handshake, with no data loss.
- rst_n asserted mid-BODY. Required: all outputs are 0 asynchronously; after release ready_strip=1 and the next packet processes cleanly with no stale residue.
